// File: rtl/transmissao_serial_uc_pkg.sv
// Shared definitions for the serial-telemetry control unit of the snake game:
// state encodings, default frame/period/watchdog sizes and a width helper.
package transmissao_pkg;

    typedef enum logic [3:0] {
        OCIOSO    = 4'd0,
        PREPARA   = 4'd1,
        TRANSMITE = 4'd2,
        ESPERA    = 4'd3,
        PROXIMO   = 4'd4,
        FIM       = 4'd5,
        ERRO      = 4'd6
    } estado_t;

    localparam int N_DIGITOS_PADRAO = 6;
    localparam int PERIODO_PADRAO   = 5_000_000;
    localparam int TIMEOUT_PADRAO   = 2_000;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int largura(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/transmissao_serial_uc_temporizador_periodico.sv
// Counter 0..PERIODO-1 with enable; held at zero while disabled. tick marks the
// last count. With SATURA set it sticks at the last count (watchdog use).
module temporizador_periodico
    import transmissao_pkg::*;
#(
    parameter int PERIODO = PERIODO_PADRAO,
    parameter bit SATURA  = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic habilita,
    output logic tick
);

    localparam int W = largura(PERIODO);
    localparam logic [W-1:0] MAXIMO = W'(PERIODO - 1);
    localparam logic [W-1:0] UM     = W'(1);
    localparam logic [W-1:0] ZERO   = W'(0);

    logic [W-1:0] valor_r;

    // Count while enabled, wrapping (or saturating) at the last count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor_r <= ZERO;
        end else if (!habilita) begin
            valor_r <= ZERO;
        end else if (valor_r == MAXIMO) begin
            valor_r <= SATURA ? MAXIMO : ZERO;
        end else begin
            valor_r <= valor_r + UM;
        end
    end

    assign tick = habilita && (valor_r == MAXIMO);

endmodule

// File: rtl/transmissao_serial_uc.sv
// Control unit sequencing the serial-telemetry datapath: one frame of N_DIGITOS
// characters per request, with request coalescing and a per-character watchdog.
module transmissao_serial_uc
    import transmissao_pkg::*;
#(
    parameter int N_DIGITOS = N_DIGITOS_PADRAO,
    parameter int PERIODO   = PERIODO_PADRAO,
    parameter int TIMEOUT   = TIMEOUT_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       envia,
    input  logic       habilita_periodico,
    input  logic       fim_digito,
    output logic       zera_contador,
    output logic       comeca_transmissao,
    output logic       conta_digito,
    output logic       ocupado,
    output logic       fim_quadro,
    output logic       erro_timeout,
    output logic [3:0] db_estado
);

    localparam logic [2:0] ULTIMO = 3'(N_DIGITOS - 1);

    estado_t    estado_r;
    logic [2:0] indice_r;
    logic       pendente_r;
    logic       primeira_espera_r;
    logic       tick_periodico_s;
    logic       estouro_s;
    logic       vigia_habilita_s;
    logic       requisicao_s;

    temporizador_periodico #(.PERIODO(PERIODO), .SATURA(1'b0)) u_periodo (
        .clock    (clock),
        .reset    (reset),
        .habilita (habilita_periodico),
        .tick     (tick_periodico_s)
    );

    // The watchdog runs from TRANSMITE so the full TIMEOUT covers the character.
    assign vigia_habilita_s = (estado_r == TRANSMITE) || (estado_r == ESPERA);

    temporizador_periodico #(.PERIODO(TIMEOUT), .SATURA(1'b1)) u_vigia (
        .clock    (clock),
        .reset    (reset),
        .habilita (vigia_habilita_s),
        .tick     (estouro_s)
    );

    assign requisicao_s = envia || tick_periodico_s;
    assign db_estado    = estado_r;

    // Pending request: collapses any requests seen while a frame is in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pendente_r <= 1'b0;
        end else if (estado_r == OCIOSO) begin
            pendente_r <= 1'b0;
        end else if (requisicao_s) begin
            pendente_r <= 1'b1;
        end else begin
            pendente_r <= pendente_r;
        end
    end

    // Frame FSM; outputs are registered together with the state they belong to.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_r           <= OCIOSO;
            indice_r           <= 3'd0;
            primeira_espera_r  <= 1'b0;
            zera_contador      <= 1'b0;
            comeca_transmissao <= 1'b0;
            conta_digito       <= 1'b0;
            ocupado            <= 1'b0;
            fim_quadro         <= 1'b0;
            erro_timeout       <= 1'b0;
        end else begin
            zera_contador      <= 1'b0;
            comeca_transmissao <= 1'b0;
            conta_digito       <= 1'b0;
            fim_quadro         <= 1'b0;
            erro_timeout       <= 1'b0;
            ocupado            <= 1'b1;
            case (estado_r)
                OCIOSO: begin
                    if (requisicao_s || pendente_r) begin
                        estado_r      <= PREPARA;
                        zera_contador <= 1'b1;
                    end else begin
                        estado_r <= OCIOSO;
                        ocupado  <= 1'b0;
                    end
                end
                PREPARA: begin
                    indice_r           <= 3'd0;
                    estado_r           <= TRANSMITE;
                    comeca_transmissao <= 1'b1;
                end
                TRANSMITE: begin
                    primeira_espera_r <= 1'b1;
                    estado_r          <= ESPERA;
                end
                ESPERA: begin
                    // A done level left over from the previous character is ignored.
                    primeira_espera_r <= 1'b0;
                    if (!primeira_espera_r && fim_digito) begin
                        estado_r     <= PROXIMO;
                        conta_digito <= 1'b1;
                    end else if (estouro_s) begin
                        estado_r     <= ERRO;
                        erro_timeout <= 1'b1;
                    end else begin
                        estado_r <= ESPERA;
                    end
                end
                PROXIMO: begin
                    indice_r <= indice_r + 3'd1;
                    if (indice_r == ULTIMO) begin
                        estado_r   <= FIM;
                        fim_quadro <= 1'b1;
                    end else begin
                        estado_r           <= TRANSMITE;
                        comeca_transmissao <= 1'b1;
                    end
                end
                FIM: begin
                    estado_r <= OCIOSO;
                    ocupado  <= 1'b0;
                end
                ERRO: begin
                    estado_r <= OCIOSO;
                    ocupado  <= 1'b0;
                end
                default: begin
                    estado_r <= OCIOSO;
                    ocupado  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transmissao_serial_uc.sv
// Directed bench for transmissao_serial_uc: a cycle table for one fast frame
// plus hand-written sequences for coalescing, watchdog, periodic and reset cases.
module tb_transmissao_serial_uc;

    logic       clock = 1'b0;
    logic       reset;
    logic       envia;
    logic       habilita_periodico;
    logic       fim_manual;
    logic       fim_modelo = 1'b0;
    logic       modo_modelo;
    logic       fim_digito;
    logic       zera_contador, comeca_transmissao, conta_digito;
    logic       ocupado, fim_quadro, erro_timeout;
    logic [3:0] db_estado;

    int nvec = 0;
    int nerr = 0;
    int ciclo = 0, atraso = 0;
    int n_zera = 0, n_comeca = 0, n_conta = 0, n_fim = 0, n_erro = 0;
    int ultimo_zera = 0, ultimo_comeca = 0, ultimo_fim = 0, ultimo_erro = 0;

    always #5 clock = ~clock;

    assign fim_digito = modo_modelo ? fim_modelo : fim_manual;

    transmissao_serial_uc #(.N_DIGITOS(6), .PERIODO(100), .TIMEOUT(20)) dut (
        .clock              (clock),
        .reset              (reset),
        .envia              (envia),
        .habilita_periodico (habilita_periodico),
        .fim_digito         (fim_digito),
        .zera_contador      (zera_contador),
        .comeca_transmissao (comeca_transmissao),
        .conta_digito       (conta_digito),
        .ocupado            (ocupado),
        .fim_quadro         (fim_quadro),
        .erro_timeout       (erro_timeout),
        .db_estado          (db_estado)
    );

    // Output pulse counters plus a transmitter answering 10 cycles after each start.
    always @(posedge clock) begin
        #1;
        ciclo++;
        if (zera_contador) begin n_zera++; ultimo_zera = ciclo; end
        if (conta_digito) n_conta++;
        if (fim_quadro) begin n_fim++; ultimo_fim = ciclo; end
        if (erro_timeout) begin n_erro++; ultimo_erro = ciclo; end
        if (comeca_transmissao) begin
            n_comeca++; ultimo_comeca = ciclo; atraso = 11;
        end else if (atraso > 0) begin
            atraso--;
        end
        fim_modelo = (atraso == 1);
    end

    typedef struct {
        logic       envia;
        logic       fim;
        logic [9:0] esperado;
    } vetor_t;

    vetor_t tabela[$];

    function automatic void adiciona(logic e, logic f, logic [5:0] s, logic [3:0] est);
        vetor_t v;
        v.envia    = e;
        v.fim      = f;
        v.esperado = {s, est};
        tabela.push_back(v);
    endfunction

    task automatic verifica(input string nome, input int obtido, input int esperado);
        nvec++;
        if (obtido != esperado) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nome, obtido, esperado);
        end
    endtask

    task automatic pulsa_envia();
        envia = 1'b1;
        @(negedge clock);
        envia = 1'b0;
    endtask

    task automatic ciclos(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    function automatic int saidas();
        return {22'd0, zera_contador, comeca_transmissao, conta_digito, ocupado,
                fim_quadro, erro_timeout, db_estado};
    endfunction

    initial begin
        int b_zera, b_conta, b_comeca, b_fim, b_erro, z1, z2, z3, fim1, limite;
        bit ok;

        // outputs {zera,comeca,conta,ocupado,fim_quadro,erro} and state, per cycle
        adiciona(1'b1, 1'b1, 6'b100100, 4'd1);
        for (int c = 0; c < 6; c++) begin
            adiciona(1'b0, 1'b1, 6'b010100, 4'd2);
            adiciona(1'b0, 1'b1, 6'b000100, 4'd3);
            adiciona(1'b0, 1'b1, 6'b000100, 4'd3);
            adiciona(1'b0, 1'b1, 6'b001100, 4'd4);
        end
        adiciona(1'b0, 1'b1, 6'b000110, 4'd5);
        adiciona(1'b0, 1'b1, 6'b000000, 4'd0);

        reset = 1'b0; envia = 1'b0; habilita_periodico = 1'b0;
        fim_manual = 1'b0; modo_modelo = 1'b0;
        #1;
        verifica("reset_outputs", saidas(), 0);
        ciclos(3);
        reset = 1'b1;
        ciclos(100);
        verifica("idle_no_frame", n_zera, 0);
        verifica("idle_state", int'(db_estado), 0);

        // Fast frame: done held high, so every character takes exactly 4 cycles
        for (int i = 0; i < tabela.size(); i++) begin
            envia      = tabela[i].envia;
            fim_manual = tabela[i].fim;
            @(negedge clock);
            nvec++;
            if (saidas() != int'(tabela[i].esperado)) begin
                nerr++;
                $display("FAIL table[%0d]: got %h, expected %h", i, saidas(), tabela[i].esperado);
            end
        end

        // Slow transmitter frame
        modo_modelo = 1'b1; fim_manual = 1'b0;
        b_zera = n_zera; b_comeca = n_comeca; b_conta = n_conta; b_fim = n_fim; b_erro = n_erro;
        pulsa_envia();
        verifica("slow_ocupado_start", int'(ocupado), 1);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clock);
            if (fim_quadro) begin
                ok = 1'b1;
                verifica("slow_ocupado_fim", int'(ocupado), 1);
            end
        end
        verifica("slow_frame_done_in_time", int'(ok), 1);
        @(negedge clock);
        verifica("slow_zera", n_zera - b_zera, 1);
        verifica("slow_comeca", n_comeca - b_comeca, 6);
        verifica("slow_conta", n_conta - b_conta, 6);
        verifica("slow_fim", n_fim - b_fim, 1);
        verifica("slow_erro", n_erro - b_erro, 0);
        verifica("slow_ocupado_end", int'(ocupado), 0);

        // Three requests mid-frame coalesce into one extra frame
        b_zera = n_zera; b_conta = n_conta; b_fim = n_fim;
        pulsa_envia();
        ciclos(20);
        for (int k = 0; k < 3; k++) begin pulsa_envia(); ciclos(5); end
        fim1 = 0; limite = 0;
        while (n_fim - b_fim < 2 && limite < 1000) begin
            @(negedge clock);
            if (n_fim - b_fim == 1 && fim1 == 0) fim1 = ultimo_fim;
            limite++;
        end
        verifica("coalesce_done_in_time", int'(n_fim - b_fim >= 2), 1);
        verifica("coalesce_back_to_back", ultimo_zera - fim1, 2);
        ciclos(60);
        verifica("coalesce_zera", n_zera - b_zera, 2);
        verifica("coalesce_conta", n_conta - b_conta, 12);

        // Watchdog: no done ever; a request during the stuck frame retries once
        modo_modelo = 1'b0; fim_manual = 1'b0;
        b_zera = n_zera; b_conta = n_conta; b_fim = n_fim; b_erro = n_erro;
        pulsa_envia();
        ciclos(5);
        pulsa_envia();
        limite = 0;
        while (n_erro == b_erro && limite < 100) begin @(negedge clock); limite++; end
        verifica("timeout_seen", n_erro - b_erro, 1);
        verifica("timeout_latency", ultimo_erro - ultimo_comeca, 20);
        @(negedge clock);
        verifica("timeout_to_idle", int'(db_estado), 0);
        @(negedge clock);
        verifica("timeout_retry_zera", n_zera - b_zera, 2);
        ciclos(60);
        verifica("timeout_erro_total", n_erro - b_erro, 2);
        verifica("timeout_no_fim", n_fim - b_fim, 0);
        verifica("timeout_no_conta", n_conta - b_conta, 0);
        verifica("timeout_no_more", n_zera - b_zera, 2);

        // Periodic requests every 100 cycles, fast transmitter
        fim_manual = 1'b1;
        b_zera = n_zera; b_fim = n_fim;
        habilita_periodico = 1'b1;
        z1 = 0; z2 = 0; z3 = 0; limite = 0;
        while (n_zera - b_zera < 3 && limite < 400) begin
            @(negedge clock);
            if (n_zera - b_zera == 1 && z1 == 0) z1 = ultimo_zera;
            if (n_zera - b_zera == 2 && z2 == 0) z2 = ultimo_zera;
            if (n_zera - b_zera == 3 && z3 == 0) z3 = ultimo_zera;
            limite++;
        end
        verifica("periodic_three_frames", n_zera - b_zera, 3);
        verifica("periodic_gap_1", z2 - z1, 100);
        verifica("periodic_gap_2", z3 - z2, 100);
        ciclos(5);
        habilita_periodico = 1'b0;
        ciclos(40);
        verifica("periodic_last_completes", n_fim - b_fim, 3);
        ciclos(250);
        verifica("periodic_stopped", n_zera - b_zera, 3);

        // Asynchronous reset in ESPERA of the third character
        modo_modelo = 1'b1; fim_manual = 1'b0;
        b_conta = n_conta;
        pulsa_envia();
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (n_conta - b_conta == 2 && db_estado == 4'd3) ok = 1'b1;
        end
        verifica("reset_reached_third_wait", int'(ok), 1);
        reset = 1'b0;
        #1;
        verifica("reset_async_outputs", saidas(), 0);
        ciclos(12);
        reset = 1'b1;
        ciclos(2);
        b_zera = n_zera; b_conta = n_conta; b_fim = n_fim;
        pulsa_envia();
        limite = 0;
        while (n_fim == b_fim && limite < 300) begin @(negedge clock); limite++; end
        verifica("after_reset_fim", n_fim - b_fim, 1);
        verifica("after_reset_conta", n_conta - b_conta, 6);
        verifica("after_reset_zera", n_zera - b_zera, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/transmissao_serial_uc.md
Name: transmissao_serial_uc

Overview:
Control unit that sequences the serial-telemetry datapath of the snake game. On a request, or on a periodic tick, it clears the datapath digit counter and captures a snapshot. It then sends N_DIGITOS characters, one per handshake: start pulse out, wait for done, advance pulse out. Requests arriving mid-frame are coalesced into a single pending frame, and a per-character watchdog aborts stuck frames.

Parameters:
N_DIGITOS, 6, characters per frame (STX, head, apple, state, modes, LF); range 1..8
PERIODO, 5_000_000, clock cycles between periodic frame requests
TIMEOUT, 2_000, maximum cycles to wait for fim_digito per character

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
envia  in  1  frame request pulse from game logic (e.g. apple eaten)
habilita_periodico  in  1  enables periodic requests
fim_digito  in  1  transmitter done for the current character
zera_contador  out  1  clears the datapath digit counter and captures the snapshot
comeca_transmissao  out  1  starts transmission of the current character
conta_digito  out  1  advances the datapath digit counter
ocupado  out  1  frame in progress (any state except OCIOSO)
fim_quadro  out  1  one-cycle pulse: frame completed
erro_timeout  out  1  one-cycle pulse: frame aborted by watchdog
db_estado  out  4  current state encoding, for debug

Behaviour:
- Reset (reset=0, asynchronous):
  - state=OCIOSO; all outputs 0; db_estado=0.
  - Digit index, watchdog, period timer and pendente all cleared.
- All outputs are Moore, decoded from registered state; no combinational path from input to output.
- States (db_estado): OCIOSO=0, PREPARA=1, TRANSMITE=2, ESPERA=3, PROXIMO=4, FIM=5, ERRO=6. Unused codes go to OCIOSO.
- OCIOSO: go to PREPARA if envia, tick_periodico or pendente; clear pendente on leaving.
- PREPARA: zera_contador=1 for exactly one cycle; index←0; then TRANSMITE.
- TRANSMITE: comeca_transmissao=1 for one cycle; watchdog←0; then ESPERA.
- ESPERA:
  - fim_digito is ignored in the first ESPERA cycle (guards against a stale done level).
  - From the second cycle: fim_digito=1 → PROXIMO.
  - Watchdog reaches TIMEOUT-1 without fim_digito → ERRO. If both happen in the same cycle, fim_digito wins.
- PROXIMO:
  - conta_digito=1 for one cycle; index+1.
  - If index was N_DIGITOS-1 → FIM, else → TRANSMITE.
  - The index is internal; the datapath counter's rco is not used.
- FIM: fim_quadro=1 for one cycle; then OCIOSO.
- ERRO: erro_timeout=1 for one cycle; then OCIOSO. pendente is kept, so a pending request retries.
- Period timer:
  - Free-running 0..PERIODO-1 while habilita_periodico=1; held at 0 while it is 0.
  - tick_periodico is asserted when the timer wraps.
- pendente:
  - Set by envia or tick_periodico in any state except OCIOSO.
  - Multiple requests during one frame collapse into one pending frame.
- Request latency: envia high at edge k gives zera_contador high during cycle k+1 and comeca_transmissao during k+2.
- Minimum character cost: 4 cycles (TRANSMITE, ESPERA×2, PROXIMO).
- Width rules:
  - Index is 3 bits.
  - Watchdog is clog2(TIMEOUT) bits and saturates at TIMEOUT-1.
  - Period timer is clog2(PERIODO) bits.

Decomposition:
- Package transmissao_pkg holds:
  - state encodings (4-bit constants listed above);
  - default N_DIGITOS, PERIODO and TIMEOUT constants, shared with the datapath mux size.
- One natural sub-module: temporizador_periodico (counter with enable and wrap tick), parameterised by PERIODO, reused for the watchdog with TIMEOUT.

Test Plan:
- Reset held low, then released → all outputs 0, db_estado=0; no activity for 100 cycles with habilita_periodico=0.
- envia pulse, transmitter model raises fim_digito 10 cycles after each comeca_transmissao → exactly 1 zera_contador, 6 comeca_transmissao, 6 conta_digito, then fim_quadro; ocupado high from PREPARA through FIM.
- envia pulsed 3 times during a frame → exactly one extra frame follows immediately after fim_quadro; total 12 conta_digito.
- fim_digito never asserted, TIMEOUT=20 → erro_timeout pulses 20 cycles after comeca_transmissao; state returns to OCIOSO; no fim_quadro.
- habilita_periodico=1, PERIODO=100, fast transmitter → a frame starts every 100 cycles; drop the enable mid-frame → the current frame completes and no new ticks occur.
- Reset asserted while in ESPERA on the 3rd character → outputs 0 immediately (asynchronous); after release, next envia restarts from index 0.
